// File: rtl/hb_gcd_xcel_if.sv
// rtl/hb_gcd_xcel_if.sv - manycore endpoint slave request/response bundle for hb_gcd_xcel
//
// Purpose: groups the incoming-request side of the endpoint into one port.
// Signals:
//   slave_addr     word address of the request (requester -> accelerator)
//   slave_data     write data
//   slave_mask     per-byte write enables
//   slave_type     1 = store, 0 = load
//   slave_val      request valid
//   slave_yum      request consumed this cycle (accelerator -> requester)
//   slave_ret_data response data, 0 for stores
//   slave_ret_val  response valid
// Modports: master = requester side, slave = accelerator side.
interface hb_gcd_xcel_if #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32
);
    logic [addr_width_p-1:0]   slave_addr;
    logic [data_width_p-1:0]   slave_data;
    logic [data_width_p/8-1:0] slave_mask;
    logic                      slave_type;
    logic                      slave_val;
    logic                      slave_yum;
    logic [data_width_p-1:0]   slave_ret_data;
    logic                      slave_ret_val;

    modport master (
        output slave_addr, slave_data, slave_mask, slave_type, slave_val,
        input  slave_yum, slave_ret_data, slave_ret_val
    );

    modport slave (
        input  slave_addr, slave_data, slave_mask, slave_type, slave_val,
        output slave_yum, slave_ret_data, slave_ret_val
    );
endinterface

// File: rtl/hb_gcd_xcel.sv
// rtl/hb_gcd_xcel.sv - memory-mapped subtractive-Euclid GCD accelerator on the endpoint slave port
//
// Purpose: software stores OPA/OPB, stores to CTRL to start, then polls STATUS
// or loads RESULT. One Euclid step (swap or subtract) per BUSY cycle.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    hb_gcd_xcel_if.slave request/response bundle
// CSR map (slave_addr[2:0]):
//   0 CTRL   store starts, load = {0, busy}
//   1 OPA    r/w, byte-masked
//   2 OPB    r/w, byte-masked
//   3 RESULT read-only
//   4 STATUS {0, busy, done}
//   5 CYCLES busy-cycle counter when HB_GCD_XCEL_CYCLE_COUNT_EN is defined,
//            otherwise unmapped
//   6-7      unmapped (load 0, store dropped)
module hb_gcd_xcel #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32
) (
    input  logic                clk,
    input  logic                reset,
    hb_gcd_xcel_if.slave        bus
);
    localparam int mask_width_lp = data_width_p / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_OPA    = 3'd1;
    localparam logic [2:0] CSR_OPB    = 3'd2;
    localparam logic [2:0] CSR_RESULT = 3'd3;
    localparam logic [2:0] CSR_STATUS = 3'd4;
    localparam logic [2:0] CSR_CYCLES = 3'd5;

    state_e                  state_q, state_d;
    logic [data_width_p-1:0] opa_q, opa_d;
    logic [data_width_p-1:0] opb_q, opb_d;
    logic [data_width_p-1:0] a_q, a_d;
    logic [data_width_p-1:0] b_q, b_d;
    logic [data_width_p-1:0] result_q, result_d;
    logic                    done_q, done_d;
    logic                    ret_val_q, ret_val_d;
    logic [data_width_p-1:0] ret_data_q, ret_data_d;
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
    logic [data_width_p-1:0] cycles_q, cycles_d;
`endif

    logic [2:0]              csr;
    logic                    busy;
    logic                    yum;
    logic [data_width_p-1:0] rdata;

    // Only the low three address bits select a CSR; the rest are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.slave_addr[addr_width_p-1:3];

    assign csr  = bus.slave_addr[2:0];
    assign busy = (state_q == ST_BUSY);

    function automatic logic [data_width_p-1:0] merge_bytes(
        input logic [data_width_p-1:0]  old_v,
        input logic [data_width_p-1:0]  new_v,
        input logic [mask_width_lp-1:0] mask
    );
        logic [data_width_p-1:0] r;
        r = old_v;
        for (int i = 0; i < mask_width_lp; i++) begin
            if (mask[i]) begin
                r[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return r;
    endfunction

    // While computing, only status-style loads may pass; everything else
    // (including RESULT loads and operand stores) waits for IDLE.
    always_comb begin
        yum = 1'b0;
        if (!busy) begin
            yum = bus.slave_val;
        end else begin
            yum = bus.slave_val && !bus.slave_type &&
                  ((csr == CSR_CTRL) || (csr == CSR_STATUS));
        end
    end

    // Read data is taken from the current register values, before this
    // cycle's updates land.
    always_comb begin
        rdata = '0;
        case (csr)
            CSR_CTRL:   rdata = {{(data_width_p-1){1'b0}}, busy};
            CSR_OPA:    rdata = opa_q;
            CSR_OPB:    rdata = opb_q;
            CSR_RESULT: rdata = result_q;
            CSR_STATUS: rdata = {{(data_width_p-2){1'b0}}, busy, done_q};
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
            CSR_CYCLES: rdata = cycles_q;
`endif
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        done_d     = done_q;
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
        cycles_d   = cycles_q;
`endif
        ret_val_d  = yum;
        ret_data_d = (yum && !bus.slave_type) ? rdata : '0;

        if (state_q == ST_IDLE) begin
            if (yum && bus.slave_type) begin
                case (csr)
                    CSR_CTRL: begin
                        a_d     = opa_q;
                        b_d     = opb_q;
                        done_d  = 1'b0;
                        state_d = ST_BUSY;
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
                        cycles_d = '0;
`endif
                    end
                    CSR_OPA: opa_d = merge_bytes(opa_q, bus.slave_data, bus.slave_mask);
                    CSR_OPB: opb_d = merge_bytes(opb_q, bus.slave_data, bus.slave_mask);
                    default: ;
                endcase
            end
        end else begin
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
            cycles_d = cycles_q + 1'b1;
`endif
            if (b_q == '0) begin
                result_d = a_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end else if (a_q < b_q) begin
                a_d = b_q;
                b_d = a_q;
            end else begin
                // a_q >= b_q here, so this cannot wrap.
                a_d = a_q - b_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            ret_val_q  <= 1'b0;
            ret_data_q <= '0;
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
            cycles_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            done_q     <= done_d;
            ret_val_q  <= ret_val_d;
            ret_data_q <= ret_data_d;
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
            cycles_q   <= cycles_d;
`endif
        end
    end

    assign bus.slave_yum      = yum;
    assign bus.slave_ret_val  = ret_val_q;
    assign bus.slave_ret_data = ret_data_q;

endmodule

// File: tb/tb_hb_gcd_xcel.sv
// tb/tb_hb_gcd_xcel.sv - self-checking bench for hb_gcd_xcel
module tb_hb_gcd_xcel;
    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    hb_gcd_xcel_if #(.data_width_p(32), .addr_width_p(32)) bus ();

    hb_gcd_xcel #(.data_width_p(32), .addr_width_p(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int STALL_LIMIT = 20000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: gcd by remainders, and BUSY length = subtractive steps + 1.
    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int ref_busy(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        int n;
        x = a; y = b; n = 1;
        while (y != 0) begin
            if (x < y) begin
                x = x ^ y; y = x ^ y; x = x ^ y;
            end else begin
                x = x - y;
            end
            n++;
        end
        return n;
    endfunction

    // One request; called half-way-ish into a cycle (posedge + 1), returns at
    // posedge + 1 of the cycle after acceptance, so calls chain with no bubbles.
    task automatic xfer(input logic wr, input logic [2:0] csr, input logic [31:0] wdata,
                        input logic [3:0] mask, output logic [31:0] rdata, output int stalls);
        bus.slave_val  = 1'b1;
        bus.slave_type = wr;
        bus.slave_addr = {29'b0, csr};
        bus.slave_data = wdata;
        bus.slave_mask = mask;
        stalls = 0;
        rdata  = '0;
        @(negedge clk);
        while (!bus.slave_yum && stalls < STALL_LIMIT) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.slave_yum) begin
            check("yum_timeout", 32'(bus.slave_yum), 32'd1);
            bus.slave_val = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        bus.slave_val = 1'b0;
        check("ret_val", 32'(bus.slave_ret_val), 32'd1);
        rdata = bus.slave_ret_data;
        if (wr) check("wr_ret_data", rdata, 32'd0);
    endtask

    task automatic wr_csr(input logic [2:0] csr, input logic [31:0] d, output int stalls);
        logic [31:0] unused_rd;
        xfer(1'b1, csr, d, 4'hF, unused_rd, stalls);
    endtask

    task automatic rd_csr(input logic [2:0] csr, output logic [31:0] d, output int stalls);
        xfer(1'b0, csr, 32'd0, 4'h0, d, stalls);
    endtask

    task automatic run_gcd(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        int st;
        wr_csr(3'd1, a, st);
        check({tag, "_opa_stall"}, 32'(st), 32'd0);
        wr_csr(3'd2, b, st);
        wr_csr(3'd0, 32'd0, st);
        rd_csr(3'd3, d, st);
        check({tag, "_result"}, d, ref_gcd(a, b));
        check({tag, "_stall"}, 32'(st), 32'(ref_busy(a, b)));
        rd_csr(3'd5, d, st);
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
        check({tag, "_cycles"}, d, 32'(ref_busy(a, b)));
`else
        check({tag, "_cycles"}, d, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] d;
        int st, busy_seen;
        logic [31:0] ra, rb, g;

        rst_n = 1'b0;
        bus.slave_val  = 1'b0;
        bus.slave_type = 1'b0;
        bus.slave_addr = '0;
        bus.slave_data = '0;
        bus.slave_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_yum", 32'(bus.slave_yum), 32'd0);
        check("rst_ret_val", 32'(bus.slave_ret_val), 32'd0);
        check("rst_ret_data", bus.slave_ret_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd_csr(3'd4, d, st);
        check("rst_status", d, 32'd0);
        check("rst_status_stall", 32'(st), 32'd0);
        rd_csr(3'd3, d, st);
        check("rst_result", d, 32'd0);
        @(posedge clk); #1;
        check("ret_val_one_cycle", 32'(bus.slave_ret_val), 32'd0);

        // 48,18 with stalled RESULT read, then STATUS and CTRL after completion.
        run_gcd("g48_18", 32'd48, 32'd18);
        rd_csr(3'd4, d, st);
        check("g48_18_status", d, 32'd1);
        rd_csr(3'd0, d, st);
        check("g48_18_ctrl_rd", d, 32'd0);

        run_gcd("g0_0", 32'd0, 32'd0);
        run_gcd("g7_0", 32'd7, 32'd0);
        run_gcd("g0_9", 32'd0, 32'd9);
        run_gcd("gff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_gcd("gff_55", 32'hFFFF_FFFF, 32'h5555_5555);

        // gcd(6,0): STATUS polled every cycle shows busy exactly once.
        wr_csr(3'd1, 32'd6, st);
        wr_csr(3'd2, 32'd0, st);
        wr_csr(3'd0, 32'd1, st);
        busy_seen = 0;
        d = 32'd2;
        for (int i = 0; i < 10 && d != 32'd1; i++) begin
            rd_csr(3'd4, d, st);
            if (d[1]) busy_seen++;
        end
        check("g6_0_busy_cycles", 32'(busy_seen), 32'd1);
        check("g6_0_final_status", d, 32'd1);
        rd_csr(3'd5, d, st);
`ifdef HB_GCD_XCEL_CYCLE_COUNT_EN
        check("g6_0_cycles", d, 32'd1);
`else
        check("g6_0_cycles", d, 32'd0);
`endif

        // Masked operand write and read-only RESULT.
        wr_csr(3'd1, 32'd0, st);
        xfer(1'b1, 3'd1, 32'hAABB_CCDD, 4'b0101, d, st);
        rd_csr(3'd1, d, st);
        check("opa_masked", d, 32'h00BB_00DD);
        rd_csr(3'd3, g, st);
        wr_csr(3'd3, 32'h1234_5678, st);
        rd_csr(3'd3, d, st);
        check("result_ro", d, g);
        wr_csr(3'd7, 32'hDEAD_BEEF, st);
        rd_csr(3'd7, d, st);
        check("unmapped_rd", d, 32'd0);

        // Traffic during BUSY.
        wr_csr(3'd1, 32'd2000, st);
        wr_csr(3'd2, 32'd3, st);
        wr_csr(3'd0, 32'd0, st);
        rd_csr(3'd4, d, st);
        check("busy_status", d, 32'd2);
        check("busy_status_stall", 32'(st), 32'd0);
        rd_csr(3'd0, d, st);
        check("busy_ctrl_rd", d, 32'd1);
        wr_csr(3'd1, 32'd77, st);
        check("busy_opa_stall", 32'(st), 32'(ref_busy(32'd2000, 32'd3) - 2));
        rd_csr(3'd3, d, st);
        check("busy_result", d, ref_gcd(32'd2000, 32'd3));
        check("busy_result_stall", 32'(st), 32'd0);
        rd_csr(3'd1, d, st);
        check("busy_opa_after", d, 32'd77);

        // Randomized operands sharing a large common factor.
        for (int k = 0; k < 12; k++) begin
            g  = 32'($urandom_range(1, 1 << 20));
            ra = g * 32'($urandom_range(0, 40));
            rb = g * 32'($urandom_range(0, 40));
            run_gcd($sformatf("rnd%0d", k), ra, rb);
        end

        // Reset in the middle of a long computation.
        wr_csr(3'd1, 32'd4000, st);
        wr_csr(3'd2, 32'd1, st);
        wr_csr(3'd0, 32'd0, st);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_yum", 32'(bus.slave_yum), 32'd0);
        check("midrst_ret_val", 32'(bus.slave_ret_val), 32'd0);
        check("midrst_ret_data", bus.slave_ret_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_csr(3'd4, d, st);
        check("midrst_status", d, 32'd0);
        rd_csr(3'd3, d, st);
        check("midrst_result", d, 32'd0);
        check("midrst_result_stall", 32'(st), 32'd0);
        rd_csr(3'd1, d, st);
        check("midrst_opa", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hb_gcd_xcel.md
# hb_gcd_xcel

Memory-mapped greatest-common-divisor accelerator that sits behind the manycore endpoint's slave (incoming request) port in a heterogeneous tile. Software writes two operands and a start command as remote stores, then polls status or reads the result with remote loads. The block drives only the slave accept/response side; it never issues outgoing packets.

## Interface
- data_width_p, 32, operand, result and CSR width
- addr_width_p, 32, request address width; only the low 3 bits are decoded
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- slave_addr  in  addr_width_p  word address of the incoming request
- slave_data  in  data_width_p  write data
- slave_mask  in  data_width_p/8  byte enables for writes
- slave_type  in  1  1 = write (store), 0 = read (load)
- slave_val  in  1  request valid
- slave_yum  out  1  request consumed this cycle
- slave_ret_data  out  data_width_p  response data; 0 for writes
- slave_ret_val  out  1  response valid

## Operation
- CSR index is slave_addr[2:0]:
  - 0 CTRL: a write of any data starts a computation; reads return {31'b0, busy}.
  - 1 OPA: read/write.
  - 2 OPB: read/write.
  - 3 RESULT: read-only.
  - 4 STATUS: read returns {30'b0, busy, done}.
  - 5 CYCLES: see Configuration.
  - 6–7: unmapped; reads return 0 and writes are ignored.
- Writes to OPA/OPB apply slave_mask per byte. Writes to read-only or unmapped CSRs are accepted and dropped.
- States:
  - IDLE: the block is not computing.
  - BUSY: one Euclid step per cycle.
  - Transition IDLE→BUSY is taken when a CTRL write is consumed. At that point working registers A←OPA and B←OPB, and done←0.
- BUSY step:
  - If B==0: RESULT←A, done←1, go to IDLE.
  - Else if A<B: swap A and B.
  - Else: A←A−B.
- Arithmetic is unsigned, data_width_p wide. The subtraction never underflows because it only executes when A≥B.
- Boundary results: gcd(x,0)=x, gcd(0,x)=x, gcd(0,0)=0.
- OPA/OPB keep their values during and after a computation. A new CTRL write recomputes from them.
- Accept rule:
  - In IDLE, slave_yum = slave_val.
  - In BUSY, slave_yum = slave_val only for reads of CTRL or STATUS. Every other request stalls (slave_yum=0) until the state returns to IDLE.
  - A read of RESULT therefore blocks until the answer is ready.
- slave_yum is never asserted without slave_val.
- Reset mid-computation aborts it. All registers are cleared and the state returns to IDLE.

## Timing
- Reset values: slave_yum=0, slave_ret_val=0, slave_ret_data=0, OPA=OPB=RESULT=A=B=0, done=0, busy=0, CYCLES=0, state IDLE.
- slave_yum is combinational from slave_val, slave_type, slave_addr and state.
- Response: slave_ret_val is asserted exactly one cycle after every cycle with slave_yum=1, for reads and writes alike, and for exactly one cycle per request.
- slave_ret_data is registered and valid with slave_ret_val. It holds read data, or 0 for writes.
- Back-to-back requests are accepted every cycle with no bubbles.
- Read data is the CSR value sampled in the yum cycle, before that cycle's updates.
- A CTRL write consumed at cycle t:
  - busy=1 from t+1.
  - For operands a,b, busy lasts the number of Euclid steps plus one cycle for the B==0 check.
  - The cycle done becomes 1 is the same cycle busy becomes 0.
- Example: gcd(6,0) shows busy for exactly 1 cycle.
- A RESULT read stalled during BUSY is consumed in the first IDLE cycle. It returns the new result one cycle later.

## Configuration
- HB_GCD_XCEL_CYCLE_COUNT_EN defined:
  - CSR 5 CYCLES counts BUSY cycles of the current or last computation.
  - CYCLES is cleared when a CTRL write is consumed and is read-only.
- Not defined: CSR 5 behaves as unmapped (reads 0, writes ignored) and the counter is not built.

## Test plan
- Reset, then read STATUS and RESULT → yum in the same cycle; ret_val one cycle later with data 0; all outputs 0 while reset is low.
- Write OPA=48, OPB=18, write CTRL, read RESULT → the RESULT read stalls while busy; returns 6; STATUS then reads 0x1.
- Operands (0,0), (7,0), (0,9), (0xFFFFFFFF,1) → results 0, 7, 9, 1; the last stresses a long run with no underflow.
- Masked write OPA=0xAABBCCDD with mask 4'b0101 onto 0 → OPA reads 0x00BB00DD; a write to RESULT leaves it unchanged, with a write response of 0.
- During BUSY, issue an OPA write and STATUS reads → the STATUS reads are accepted and return busy=1; the OPA write is held (yum=0) until IDLE; the in-flight result is unaffected.
- With HB_GCD_XCEL_CYCLE_COUNT_EN, gcd(6,0) → CYCLES=1; without the macro → CYCLES reads 0. Assert reset low mid-BUSY → STATUS=0, RESULT=0.
